logic_op_arbiter: RTL and testbench



---
 rtl/logic_op_arbiter.sv | 157 +++++++++++++++
 tb/tb_logic_op_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/NOR/NAND/XOR/XNOR) with a
// single-entry valid/ready result buffer. Optional macro: LOGIC_ARB_STATS_EN.
module logic_op_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_c,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [16*N_REQ-1:0]    grant_cnt
);

    // Handshake: a request transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both high; a result transfers where rsp_valid and
    // rsp_ready are both high. Both may happen on the same edge.
    typedef enum logic {S_EMPTY, S_FULL} buf_state_t;

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_c;
    logic             r_err;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    int               w_dist;
    int               w_best;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_c;
    logic             w_err;
    logic             w_can_accept;
    logic             w_accept;

    // Winner is the valid requester at the smallest rotated distance after
    // the last grant, so the search starts at last_grant+1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_dist  = 0;
        w_best  = N_REQ;
        w_op    = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(r_last_grant)) % N_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_found = 1'b1;
                w_best  = w_dist;
                w_win   = IDW'(i);
                w_op    = req_op[3*i +: 3];
                w_a     = req_a[WIDTH*i +: WIDTH];
                w_b     = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    always_comb begin
        w_c   = '0;
        w_err = 1'b0;
        case (w_op)
            3'd0:    w_c = w_a & w_b;
            3'd1:    w_c = w_a | w_b;
            3'd2:    w_c = ~(w_a | w_b);
            3'd3:    w_c = ~(w_a & w_b);
            3'd4:    w_c = w_a ^ w_b;
            3'd5:    w_c = ~(w_a ^ w_b);
            default: w_err = 1'b1;
        endcase
    end

    assign w_can_accept = (r_state == S_EMPTY) || rsp_ready;
    assign w_accept     = w_found && w_can_accept;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_accept && (w_win == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A same-edge drain and accept keeps the buffer FULL with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (!w_accept && rsp_ready) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDW'(N_REQ - 1);
            r_id         <= '0;
            r_c          <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_last_grant <= w_win;
            r_id         <= w_win;
            r_c          <= w_c;
            r_err        <= w_err;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_id    = r_id;
    assign rsp_c     = r_c;
    assign rsp_err   = r_err;
    assign busy      = (r_state == S_FULL) || (|req_valid);

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] r_cnt [N_REQ];

    // Per-requester accept counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && (w_win == IDW'(i)) && (r_cnt[i] != 16'hFFFF)) begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) grant_cnt[16*i +: 16] = r_cnt[i];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: behavioural model checked every
// cycle, directed literal scenarios, then randomized traffic.
module tb_logic_op_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [3*N-1:0]   req_op;
  logic [W*N-1:0]   req_a;
  logic [W*N-1:0]   req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_c;
  logic             rsp_err;
  logic             busy;
  logic [16*N-1:0]  grant_cnt;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic_op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid;
  int           m_id;
  logic [W-1:0] m_c;
  logic         m_err;
  int           m_last;
  int           m_cnt [N];

  function automatic logic [W-1:0] op_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < W; j++) begin
      int ones;
      ones = int'(a[j]) + int'(b[j]);
      case (op)
        0: r[j] = (ones == 2);
        1: r[j] = (ones >= 1);
        2: r[j] = (ones == 0);
        3: r[j] = (ones != 2);
        4: r[j] = (ones == 1);
        5: r[j] = (ones != 1);
        default: r[j] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // First valid requester walking forward from m_last+1, or -1.
  function automatic int model_winner();
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_id    <= 0;
      m_c     <= '0;
      m_err   <= 1'b0;
      m_last  <= N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
    end else begin
      int w;
      w = model_winner();
      if (w >= 0 && (!m_valid || rsp_ready)) begin
        int op;
        op = int'(req_op[3*w +: 3]);
        m_valid <= 1'b1;
        m_id    <= w;
        m_c     <= op_ref(op, req_a[W*w +: W], req_b[W*w +: W]);
        m_err   <= (op > 5);
        m_last  <= w;
        if (m_cnt[w] < 65535) m_cnt[w] <= m_cnt[w] + 1;
      end else if (m_valid && rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0]    exp_rdy;
      logic [16*N-1:0] exp_cnt;
      int w;
      exp_rdy = '0;
      exp_cnt = '0;
      w = model_winner();
      if (rst_n && w >= 0 && (!m_valid || rsp_ready)) exp_rdy[w] = 1'b1;
`ifdef LOGIC_ARB_STATS_EN
      for (int i = 0; i < N; i++) exp_cnt[16*i +: 16] = 16'(m_cnt[i]);
`endif
      if (rst_n) begin
        chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("m_busy", 64'(busy), 64'(m_valid || (|req_valid)));
      end
      chk("m_rsp_valid", 64'(rsp_valid), 64'(m_valid));
      chk("m_rsp_id", 64'(rsp_id), 64'(m_id));
      chk("m_rsp_c", 64'(rsp_c), 64'(m_c));
      chk("m_rsp_err", 64'(rsp_err), 64'(m_err));
      chk("m_grant_cnt", 64'(grant_cnt), 64'(exp_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_post();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[3*i +: 3] = 3'(op);
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]   sweep_exp [7];
  logic [IDW-1:0] saved_id;
  logic [W-1:0]   saved_c;
  logic [N-1:0]   acc;
  logic [N-1:0]   one_hot;

  initial begin
    sweep_exp[0] = 8'h05; sweep_exp[1] = 8'hAF; sweep_exp[2] = 8'h50;
    sweep_exp[3] = 8'hFA; sweep_exp[4] = 8'hAA; sweep_exp[5] = 8'h55;
    sweep_exp[6] = 8'h00;

    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    to_neg();
    rst_n = 1'b1;
    to_neg();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_c", 64'(rsp_c), 64'd0);
    chk("reset_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // First transaction: AND of F0, 3C.
    to_post();
    req_valid = 4'b0001; set_req(0, 0, 8'hF0, 8'h3C); rsp_ready = 1'b1;
    to_neg();
    chk("first_req_ready", 64'(req_ready), 64'h1);
    to_post();
    req_valid = '0;
    to_neg();
    chk("first_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("first_rsp_id", 64'(rsp_id), 64'd0);
    chk("first_rsp_c", 64'(rsp_c), 64'h30);
    chk("first_rsp_err", 64'(rsp_err), 64'd0);

    // All four held valid: grants rotate 1,2,3,0,... with no gaps.
    to_post();
    for (int i = 0; i < N; i++) set_req(i, i, 8'(8'h11 * (i + 1)), 8'h5A);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      to_post();
      to_neg();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rr_rsp_id", 64'(rsp_id), 64'((1 + k) % N));
    end
    to_post();
    req_valid = '0;
    to_post();

    // Op sweep on requester 2.
    for (int op = 0; op < 7; op++) begin
      req_valid = 4'b0100; set_req(2, op, 8'hA5, 8'h0F);
      to_post();
      req_valid = '0;
      to_neg();
      chk("sweep_rsp_c", 64'(rsp_c), 64'(sweep_exp[op]));
      chk("sweep_rsp_err", 64'(rsp_err), 64'(op == 6));
      to_post();
    end

    // Backpressure: buffer FULL, consumer stalled for 5 cycles.
    for (int i = 0; i < N; i++) set_req(i, 4, 8'(i * 37), 8'hC3);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    to_post();
    rsp_ready = 1'b0;
    to_neg();
    saved_id = rsp_id; saved_c = rsp_c;
    chk("bp_full", 64'(rsp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_rsp_id_stable", 64'(rsp_id), 64'(saved_id));
      chk("bp_rsp_c_stable", 64'(rsp_c), 64'(saved_c));
      to_post();
    end
    rsp_ready = 1'b1;
    to_neg();
    one_hot = '0;
    one_hot[(int'(saved_id) + 1) % N] = 1'b1;
    chk("bp_release_ready", 64'(req_ready), 64'(one_hot));
    to_post();
    to_neg();
    chk("bp_no_bubble", 64'(rsp_valid), 64'd1);
    chk("bp_next_id", 64'(rsp_id), 64'((int'(saved_id) + 1) % N));

    // Asynchronous reset while FULL.
    to_post();
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    to_neg();
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 64'(req_ready), 64'h1);
    to_post();
    req_valid = '0;
    to_neg();
    chk("post_rst_id", 64'(rsp_id), 64'd0);
    to_post();

    // Randomized traffic honouring hold-until-accepted.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      to_neg();
      acc = req_valid & req_ready;
      to_post();
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          set_req(i, int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0; rsp_ready = 1'b1;
    to_post();
    to_post();

`ifdef LOGIC_ARB_STATS_EN
    // Saturate requester 1's counter; others stay at their model values.
    rst_n = 1'b0;
    to_neg();
    rst_n = 1'b1;
    to_post();
    req_valid = 4'b0010; set_req(1, 1, 8'h0F, 8'hF0);
    repeat (70000) @(posedge clk);
    #1 req_valid = '0;
    to_neg();
    chk("stats_sat_1", 64'(grant_cnt[31:16]), 64'hFFFF);
    chk("stats_others", 64'({grant_cnt[63:32], grant_cnt[15:0]}), 64'd0);
`else
    to_neg();
    chk("stats_off_zero", 64'(grant_cnt), 64'd0);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
